// File: rtl/pe_pkg.sv
// Shared types for the PE array and its command sequencer: opcode/algorithm
// encodings, the array pipeline latency and the controller state encoding.
package pe_pkg;

    typedef enum logic [4:0] {
        INSTR_NTT    = 5'd0,
        INSTR_INTT   = 5'd1,
        INSTR_KMAC   = 5'd2,
        INSTR_PWM    = 5'd3,
        INSTR_ADD    = 5'd4,
        INSTR_SUB    = 5'd5,
        INSTR_BYPASS = 5'd31
    } pe_instr_t;

    typedef enum logic [4:0] {
        ALG_KEM_512  = 5'd0,
        ALG_KEM_768  = 5'd1,
        ALG_KEM_1024 = 5'd2,
        ALG_DSA_44   = 5'd3,
        ALG_DSA_65   = 5'd4,
        ALG_DSA_87   = 5'd5
    } pe_alg_t;

    // Cycles from a beat entering pe_array.data_in to its result on data_out.
    localparam int PE_PIPE_LAT = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } ctrl_state_t;

endpackage

// File: rtl/pe_ctrl_delay.sv
// Valid-only delay line that follows each beat through the PE array pipeline;
// its output marks the cycle in which the matching result must be written.
module pe_ctrl_delay #(
    parameter int DEPTH = 6
) (
    input  logic clk,
    input  logic rst,
    input  logic valid_in,
    output logic valid_out
);

    logic [DEPTH-1:0] taps_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            taps_q <= '0;
        end else begin
            taps_q[0] <= valid_in;
            for (int i = 1; i < DEPTH; i++) begin
                taps_q[i] <= taps_q[i-1];
            end
        end
    end

    assign valid_out = taps_q[DEPTH-1];

endmodule

// File: rtl/pe_array_ctrl.sv
// Command sequencer for the PE array: streams operand words from memory into the
// array one beat per cycle and writes the array results back to result memory.
module pe_array_ctrl
    import pe_pkg::*;
#(
    parameter int WIDTH    = 24,
    parameter int NUM      = 4,
    parameter int IN_NUM   = 3,
    parameter int OUT_NUM  = 2,
    parameter int ADDR_W   = 8,
    parameter int LEN_W    = 8,
    parameter int PIPE_LAT = PE_PIPE_LAT
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [4:0]                   cmd_instr,
    input  logic [4:0]                   cmd_alg,
    input  logic [LEN_W-1:0]             cmd_len,
    input  logic [ADDR_W-1:0]            cmd_src,
    input  logic [ADDR_W-1:0]            cmd_dst,
    output logic                         rd_en,
    output logic [ADDR_W-1:0]            rd_addr,
    input  logic [NUM*IN_NUM*WIDTH-1:0]  rd_data,
    output logic [4:0]                   pe_instr,
    output logic [4:0]                   pe_alg,
    output logic [NUM*IN_NUM*WIDTH-1:0]  pe_data_in,
    input  logic [NUM*OUT_NUM*WIDTH-1:0] pe_data_out,
    output logic                         wr_en,
    output logic [ADDR_W-1:0]            wr_addr,
    output logic [NUM*OUT_NUM*WIDTH-1:0] wr_data,
    output logic                         busy,
    output logic                         done
);

    localparam int DIN_W = NUM * IN_NUM * WIDTH;

    ctrl_state_t       state_q;
    ctrl_state_t       state_d;
    pe_instr_t         instr_q;
    pe_alg_t           alg_q;
    logic [LEN_W-1:0]  len_q;
    logic [ADDR_W-1:0] src_q;
    logic [LEN_W-1:0]  rd_cnt_q;
    logic [LEN_W-1:0]  wr_cnt_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic              rd_valid_q;
    logic              beat_valid_q;
    logic [DIN_W-1:0]  data_in_q;
    logic              wr_valid;
    logic              accept;
    logic              last_rd;
    logic              last_wr;

    assign accept  = cmd_valid && (state_q == IDLE);
    assign last_rd = (rd_cnt_q == len_q - LEN_W'(1));
    assign last_wr = wr_valid && (wr_cnt_q == len_q - LEN_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A zero-length command skips straight to DONE so it still produces a done pulse.
    always_comb begin
        state_d   = state_q;
        cmd_ready = 1'b0;
        rd_en     = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state_q)
            IDLE: begin
                busy      = 1'b0;
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    state_d = (cmd_len == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                rd_en = 1'b1;
                if (last_rd) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (last_wr) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Opcode and algorithm stay on the array until the next command replaces them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_q <= INSTR_BYPASS;
            alg_q   <= ALG_KEM_512;
            len_q   <= '0;
            src_q   <= '0;
        end else if (accept) begin
            instr_q <= pe_instr_t'(cmd_instr);
            alg_q   <= pe_alg_t'(cmd_alg);
            len_q   <= cmd_len;
            src_q   <= cmd_src;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_cnt_q <= '0;
        end else if (accept) begin
            rd_cnt_q <= '0;
        end else if (state_q == ISSUE) begin
            rd_cnt_q <= rd_cnt_q + LEN_W'(1);
        end
    end

    assign rd_addr = src_q + ADDR_W'(rd_cnt_q);

    // Operand words arrive one cycle after the read strobe; idle cycles present zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid_q   <= 1'b0;
            beat_valid_q <= 1'b0;
            data_in_q    <= '0;
        end else begin
            rd_valid_q   <= rd_en;
            beat_valid_q <= rd_valid_q;
            data_in_q    <= rd_valid_q ? rd_data : '0;
        end
    end

    pe_ctrl_delay #(
        .DEPTH (PIPE_LAT)
    ) u_delay (
        .clk       (clk),
        .rst       (rst),
        .valid_in  (beat_valid_q),
        .valid_out (wr_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_addr_q <= '0;
            wr_cnt_q  <= '0;
        end else if (accept) begin
            wr_addr_q <= cmd_dst;
            wr_cnt_q  <= '0;
        end else if (wr_valid) begin
            wr_addr_q <= wr_addr_q + ADDR_W'(1);
            wr_cnt_q  <= wr_cnt_q + LEN_W'(1);
        end
    end

    assign pe_instr   = instr_q;
    assign pe_alg     = alg_q;
    assign pe_data_in = data_in_q;
    assign wr_en      = wr_valid;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = pe_data_out;

endmodule
